// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

   localparam int XLEN_DEF = 32;

   // Stage indices; a stall/flush vector bit k controls the register feeding stage k
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MDU  = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE  = 3'd0,
      CAUSE_IFU   = 3'd1,
      CAUSE_LDUSE = 3'd2,
      CAUSE_REDIR = 3'd3,
      CAUSE_MDU   = 3'd4,
      CAUSE_LSU   = 3'd5,
      CAUSE_TRAP  = 3'd6
   } cause_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : Hazard-source inputs and stall/flush/redirect outputs of the core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);
   logic            ifu_wait;
   logic            lsu_wait;
   logic            id_load_use;
   logic            ex_mdu_start;
   logic            ex_redirect;
   logic [XLEN-1:0] ex_redirect_pc;
   logic            wb_trap;
   logic [XLEN-1:0] wb_trap_pc;

   logic            pc_stall;
   logic            pc_redirect_vld;
   logic [XLEN-1:0] pc_redirect_pc;
   logic            if_id_stall;
   logic            id_ex_stall;
   logic            ex_mem_stall;
   logic            if_id_flush;
   logic            id_ex_flush;
   logic            ex_mem_flush;
   logic            mem_wb_flush;
   logic            mdu_busy;

   modport master (
      output ifu_wait, lsu_wait, id_load_use, ex_mdu_start,
             ex_redirect, ex_redirect_pc, wb_trap, wb_trap_pc,
      input  pc_stall, pc_redirect_vld, pc_redirect_pc,
             if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mdu_busy
   );

   modport slave (
      input  ifu_wait, lsu_wait, id_load_use, ex_mdu_start,
             ex_redirect, ex_redirect_pc, wb_trap, wb_trap_pc,
      output pc_stall, pc_redirect_vld, pc_redirect_pc,
             if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mdu_busy
   );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mdu_wait_cnt.sv
// ============================================================================
// Module : mdu_wait_cnt
// Brief  : Loadable down-counter with clear and zero flag for the MDU wait.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_wait_cnt
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // Clear beats load beats decrement; decrement saturates at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Stall/flush scheduler for the 5-stage pipeline, MDU wait sequencing
//          and pending PC redirect. Optional perf counters: PIPE_HAZARD_CTRL_PERF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_CYCLES = 33,
   parameter int CNT_W      = 6,
   parameter int XLEN       = XLEN_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt
`endif
);

   state_t              r_state;
   logic                r_mdu_busy;
   logic                r_redir_pend;
   logic [XLEN-1:0]     r_redir_pc;

   logic [CNT_W-1:0]    w_cnt;
   logic                w_cnt_zero;
   logic                w_cnt_last;
   logic                w_start;
   logic                w_in_mdu;
   cause_t              w_cause;
   logic [STG_MEM:STG_IF] w_stall;
   logic [STG_WB:STG_ID]  w_flush_raw;
   logic [STG_WB:STG_ID]  w_flush;
   logic                w_redir_vld;
   logic [XLEN-1:0]     w_redir_pc;
   logic                w_pc_stall;

   assign w_in_mdu   = (r_state == ST_MDU);
   assign w_start    = (r_state == ST_IDLE) && hz.ex_mdu_start && !hz.lsu_wait && !hz.wb_trap;
   // Counter is loaded with MDU_CYCLES-1; it reaches zero on the edge that leaves MDU
   assign w_cnt_last = w_cnt_zero || (w_cnt == CNT_W'(1));

   mdu_wait_cnt #(
      .CNT_W      (CNT_W)
   ) u_mdu_wait_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_start),
      .i_load_val (CNT_W'(MDU_CYCLES - 1)),
      .i_dec      (w_in_mdu),
      .i_clr      (hz.wb_trap),
      .o_cnt      (w_cnt),
      .o_zero     (w_cnt_zero)
   );

   always_comb begin
      w_cause = CAUSE_NONE;
      if (hz.wb_trap)                 w_cause = CAUSE_TRAP;
      else if (hz.lsu_wait)           w_cause = CAUSE_LSU;
      else if (w_start || w_in_mdu)   w_cause = CAUSE_MDU;
      else if (hz.ex_redirect)        w_cause = CAUSE_REDIR;
      else if (hz.id_load_use)        w_cause = CAUSE_LDUSE;
      else if (hz.ifu_wait)           w_cause = CAUSE_IFU;
   end

   always_comb begin
      w_stall     = '0;
      w_flush_raw = '0;
      w_redir_vld = 1'b0;
      w_redir_pc  = hz.ex_redirect_pc;
      case (w_cause)
         CAUSE_TRAP: begin
            w_flush_raw = '1;
            w_redir_vld = 1'b1;
            w_redir_pc  = hz.wb_trap_pc;
         end
         CAUSE_LSU: begin
            w_stall             = '1;
            w_flush_raw[STG_WB] = 1'b1;
         end
         CAUSE_MDU: begin
            w_stall[STG_EX:STG_IF] = '1;
            w_flush_raw[STG_MEM]   = 1'b1;
         end
         CAUSE_REDIR: begin
            w_flush_raw[STG_EX:STG_ID] = '1;
            w_redir_vld                = !hz.ifu_wait;
         end
         CAUSE_LDUSE: begin
            w_stall[STG_ID:STG_IF] = '1;
            w_flush_raw[STG_EX]    = 1'b1;
         end
         CAUSE_IFU: begin
            w_stall[STG_IF]     = 1'b1;
            w_flush_raw[STG_ID] = 1'b1;
         end
         default: ;
      endcase
      // A fresh EX redirect supersedes the pending target when both could issue
      if (r_redir_pend && (w_cause != CAUSE_TRAP)) begin
         w_flush_raw[STG_ID] = 1'b1;
         if (!hz.ifu_wait && (w_cause != CAUSE_REDIR)) begin
            w_redir_vld = 1'b1;
            w_redir_pc  = r_redir_pc;
         end
      end
   end

   // A held register is never bubbled; a redirecting PC loads rather than holds
   assign w_flush    = w_flush_raw & ~{1'b0, w_stall[STG_MEM:STG_ID]};
   assign w_pc_stall = w_stall[STG_IF] & ~w_redir_vld;

   assign hz.pc_stall        = rst_n & w_pc_stall;
   assign hz.if_id_stall     = rst_n & w_stall[STG_ID];
   assign hz.id_ex_stall     = rst_n & w_stall[STG_EX];
   assign hz.ex_mem_stall    = rst_n & w_stall[STG_MEM];
   assign hz.if_id_flush     = !rst_n | w_flush[STG_ID];
   assign hz.id_ex_flush     = !rst_n | w_flush[STG_EX];
   assign hz.ex_mem_flush    = !rst_n | w_flush[STG_MEM];
   assign hz.mem_wb_flush    = !rst_n | w_flush[STG_WB];
   assign hz.pc_redirect_vld = rst_n & w_redir_vld;
   assign hz.pc_redirect_pc  = w_redir_pc;
   assign hz.mdu_busy        = r_mdu_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_mdu_busy   <= 1'b0;
         r_redir_pend <= 1'b0;
         r_redir_pc   <= '0;
      end else begin
         if (hz.wb_trap) begin
            r_state    <= ST_IDLE;
            r_mdu_busy <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: if (w_start) begin
                  r_state    <= ST_MDU;
                  r_mdu_busy <= 1'b1;
               end
               ST_MDU: if (w_cnt_last) begin
                  r_state    <= ST_IDLE;
                  r_mdu_busy <= 1'b0;
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_mdu_busy <= 1'b0;
               end
            endcase
         end

         if (hz.wb_trap) begin
            r_redir_pend <= 1'b0;
         end else if (w_cause == CAUSE_REDIR) begin
            r_redir_pend <= hz.ifu_wait;
            if (hz.ifu_wait) r_redir_pc <= hz.ex_redirect_pc;
         end else if (r_redir_pend && !hz.ifu_wait) begin
            r_redir_pend <= 1'b0;
         end
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall_cnt <= '0;
         r_perf_flush_cnt <= '0;
      end else begin
         if (w_pc_stall) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         if ((w_cause == CAUSE_TRAP) || (w_cause == CAUSE_REDIR))
            r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_perf_stall_cnt;
   assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

`default_nettype wire
